// File: rtl/config_ser_bridge.sv
// SPI mode-0 command front end for config_reg, oversampled in the clk domain.
// Optional CFG_PARITY_EN: 21-bit frames with a trailing even-parity bit.
module config_ser_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        cfg_write,
    output logic [2:0]  cfg_address,
    output logic [15:0] cfg_data_in,
    input  logic [15:0] cfg_data_out,
    output logic        busy,
    output logic        frame_err
);

    // state   | meaning
    // IDLE    | no frame; waits for cs_n fall
    // HDR     | shifting RW + 3-bit address
    // RD_WAIT | read frame, waiting RD_LAT cycles for cfg_data_out
    // DATA    | shifting data (write) or shifting miso out (read)
    // COMMIT  | one-cycle cfg_write
    // DONE    | write frame finished; waits for cs_n rise

`ifdef CFG_PARITY_EN
    localparam int FRAME_BITS = 21;
`else
    localparam int FRAME_BITS = 20;
`endif
    localparam int SH_W = FRAME_BITS - 4;

    typedef enum logic [2:0] {IDLE, HDR, RD_WAIT, DATA, COMMIT, DONE} state_t;
    state_t state, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, vld_sync;
    logic cs_s, sclk_s, mosi_s;
    logic cs_q, sclk_q, armed;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    logic [4:0]      bit_cnt;
    logic [1:0]      wait_cnt;
    logic [SH_W-2:0] sh;
    logic [SH_W-1:0] sh_nxt;
    logic [15:0]     data_nxt;
    logic [15:0]     tx;
    logic            rw_q, fall_pend, par_ok, err_d;
    logic            in_shift, hdr_done, last_rise;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // armed only after a genuine high cs_n has been seen, so a frame already
    // in progress at reset release cannot produce a falling edge
    assign cs_fall   = armed & cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;

    assign sh_nxt    = {sh, mosi_s};
    assign in_shift  = (state == HDR) || (state == RD_WAIT) || (state == DATA);
    assign hdr_done  = (state == HDR) && !cs_rise && sclk_rise && (bit_cnt == 5'd3);
    assign last_rise = sclk_rise && (bit_cnt == 5'(FRAME_BITS - 1));

`ifdef CFG_PARITY_EN
    logic par_q;
    assign par_ok   = ~(par_q ^ mosi_s);
    assign data_nxt = sh_nxt[16:1];
`else
    assign par_ok   = 1'b1;
    assign data_nxt = sh_nxt[15:0];
`endif

    assign busy      = (state != IDLE);
    assign cfg_write = (state == COMMIT);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        err_d   = 1'b0;
        case (state)
            IDLE: if (cs_fall) state_d = HDR;
            HDR: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (hdr_done) begin
                    state_d = sh_nxt[3] ? DATA : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (wait_cnt == 2'd0) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    err_d   = (bit_cnt < 5'(FRAME_BITS));
                end else if (last_rise) begin
                    if (rw_q) begin
                        if (par_ok) begin
                            state_d = COMMIT;
                        end else begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        err_d = !par_ok;
                    end
                end
            end
            COMMIT: state_d = cs_rise ? IDLE : DONE;
            DONE:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_sync     <= '1;
            sclk_sync   <= '0;
            mosi_sync   <= '0;
            vld_sync    <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            armed       <= 1'b0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            sh          <= '0;
            rw_q        <= 1'b0;
            tx          <= '0;
            fall_pend   <= 1'b0;
            miso        <= 1'b0;
            cfg_address <= '0;
            cfg_data_in <= '0;
            frame_err   <= 1'b0;
`ifdef CFG_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
            if (vld_sync[SYNC_STAGES-1] && cs_s) armed <= 1'b1;

            frame_err <= err_d;

            if (state == IDLE) begin
                bit_cnt   <= '0;
                fall_pend <= 1'b0;
`ifdef CFG_PARITY_EN
                par_q     <= 1'b0;
`endif
            end else if (in_shift && sclk_rise && (bit_cnt < 5'(FRAME_BITS))) begin
                bit_cnt <= bit_cnt + 5'd1;
                sh      <= sh_nxt[SH_W-2:0];
`ifdef CFG_PARITY_EN
                par_q   <= par_q ^ mosi_s;
`endif
            end

            if (hdr_done) begin
                cfg_address <= sh_nxt[2:0];
                rw_q        <= sh_nxt[3];
                wait_cnt    <= 2'(RD_LAT);
            end

            if (state == RD_WAIT) begin
                if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
                if (sclk_fall) fall_pend <= 1'b1;
            end

            // a fall seen while still waiting must present bit15 right at load
            if (state == RD_WAIT && state_d == DATA) begin
                if (fall_pend || sclk_fall) begin
                    miso <= cfg_data_out[15];
                    tx   <= {cfg_data_out[14:0], 1'b0};
                end else begin
                    tx   <= cfg_data_out;
                end
            end else if (state == DATA && !rw_q && sclk_fall) begin
                miso <= tx[15];
                tx   <= {tx[14:0], 1'b0};
            end

            if (state == DATA && state_d == COMMIT) cfg_data_in <= data_nxt;

            if (state_d == IDLE) miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_config_ser_bridge.sv
// Bench for config_ser_bridge: SPI master driver, config_reg stand-in, frame-level reference model.
module tb_config_ser_bridge;

    localparam int SYNC_STAGES = 2;
    localparam int RD_LAT      = 1;
    localparam int HALF        = 8;
`ifdef CFG_PARITY_EN
    localparam int NB = 21;
`else
    localparam int NB = 20;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, cfg_write, busy, frame_err;
    logic [2:0]  cfg_address;
    logic [15:0] cfg_data_in, cfg_data_out;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    config_ser_bridge #(.SYNC_STAGES(SYNC_STAGES), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
        .cfg_write(cfg_write), .cfg_address(cfg_address), .cfg_data_in(cfg_data_in),
        .cfg_data_out(cfg_data_out), .busy(busy), .frame_err(frame_err)
    );

    function automatic logic [15:0] def_val(input int a);
        case (a)
            0: return 16'hFFFF;
            4: return 16'hABCD;
            7: return 16'h0001;
            default: return 16'h0000;
        endcase
    endfunction

    // config_reg stand-in with RD_LAT-cycle registered read
    logic        reg_init = 1'b1;
    logic [15:0] regs [8];
    logic [15:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (reg_init) begin
            for (int i = 0; i < 8; i++) regs[i] <= def_val(i);
        end else if (cfg_write) begin
            regs[cfg_address] <= cfg_data_in;
        end
        rd_pipe[0] <= regs[cfg_address];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign cfg_data_out = rd_pipe[RD_LAT-1];

    // output monitor
    int          wr_cnt = 0, err_cnt = 0, wr_long = 0, err_long = 0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        prev_wr = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (cfg_write === 1'b1) begin
            wr_cnt++;
            wr_addr = cfg_address;
            wr_data = cfg_data_in;
            if (prev_wr) wr_long++;
        end
        if (frame_err === 1'b1) begin
            err_cnt++;
            if (prev_err) err_long++;
        end
        prev_wr  = (cfg_write === 1'b1);
        prev_err = (frame_err === 1'b1);
    end

    // reference model state, updated per frame from the frame rules
    logic [15:0] exp_mem [8];
    int          exp_wr = 0, exp_err = 0;
    logic [2:0]  exp_addr = '0;
    logic [15:0] exp_din = '0;

    function automatic logic [20:0] mk(input logic rw, input logic [2:0] a, input logic [15:0] d);
        logic [19:0] f;
        f = {rw, a, d};
`ifdef CFG_PARITY_EN
        return {f, ^f};
`else
        return {1'b0, f};
`endif
    endfunction

    task automatic xfer(input logic [20:0] f, input int nbits, input int extra, input int rst_at,
                        output logic [15:0] rd, output logic [22:0] snap, output logic busy_after);
        rd = '0;
        snap = '0;
        busy_after = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < nbits + extra; i++) begin
            if (i == rst_at) begin
                reset = 1'b0;
                repeat (3) @(negedge clk);
                snap = {miso, cfg_write, cfg_address, cfg_data_in, busy, frame_err};
                reset = 1'b1;
                repeat (6) @(negedge clk);
            end
            if (i < nbits) mosi = f[NB-1-i];
            else           mosi = 1'b0;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (i >= 4 && i < 20) rd = {rd[14:0], miso};
            if (i == rst_at + 2) busy_after = busy;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d, input int extra);
        logic [15:0] rd; logic [22:0] sn; logic ba;
        xfer(mk(1'b1, a, d), NB, extra, -1, rd, sn, ba);
    endtask

    task automatic do_read(input logic [2:0] a, output logic [15:0] rd);
        logic [22:0] sn; logic ba;
        xfer(mk(1'b0, a, 16'($urandom)), NB, 0, -1, rd, sn, ba);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        reg_init = 1'b0;
        n_checks++; if (miso !== 1'b0) begin n_errs++; $display("FAIL reset_miso: got %b want 0", miso); end
        n_checks++; if (cfg_write !== 1'b0) begin n_errs++; $display("FAIL reset_cfg_write: got %b want 0", cfg_write); end
        n_checks++; if (cfg_address !== 3'd0) begin n_errs++; $display("FAIL reset_cfg_address: got %h want 0", cfg_address); end
        n_checks++; if (cfg_data_in !== 16'h0) begin n_errs++; $display("FAIL reset_cfg_data_in: got %h want 0", cfg_data_in); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_errs++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_read_defaults;
        logic [2:0] addrs [3];
        logic [15:0] rd;
        addrs[0] = 3'd0; addrs[1] = 3'd4; addrs[2] = 3'd7;
        for (int k = 0; k < 3; k++) begin
            do_read(addrs[k], rd);
            exp_addr = addrs[k];
            n_checks++; if (rd !== exp_mem[addrs[k]]) begin n_errs++; $display("FAIL read_default a=%0d: got %h want %h", addrs[k], rd, exp_mem[addrs[k]]); end
            n_checks++; if (cfg_address !== exp_addr) begin n_errs++; $display("FAIL read_default_addr: got %0d want %0d", cfg_address, exp_addr); end
        end
        n_checks++; if (err_cnt !== exp_err) begin n_errs++; $display("FAIL read_default_err: got %0d want %0d", err_cnt, exp_err); end
    endtask

    task automatic test_write_read;
        logic [15:0] rd;
        do_write(3'd7, 16'hAA77, 0);
        exp_wr++; exp_mem[7] = 16'hAA77; exp_addr = 3'd7; exp_din = 16'hAA77;
        n_checks++; if (wr_cnt !== exp_wr) begin n_errs++; $display("FAIL write_count: got %0d want %0d", wr_cnt, exp_wr); end
        n_checks++; if (wr_addr !== 3'd7) begin n_errs++; $display("FAIL write_addr: got %0d want 7", wr_addr); end
        n_checks++; if (wr_data !== 16'hAA77) begin n_errs++; $display("FAIL write_data: got %h want aa77", wr_data); end
        n_checks++; if (cfg_data_in !== exp_din) begin n_errs++; $display("FAIL write_data_hold: got %h want %h", cfg_data_in, exp_din); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL write_busy: got %b want 0", busy); end
        do_read(3'd7, rd);
        n_checks++; if (rd !== exp_mem[7]) begin n_errs++; $display("FAIL write_readback: got %h want %h", rd, exp_mem[7]); end
    endtask

    task automatic test_abort;
        logic [15:0] rd; logic [22:0] sn; logic ba;
        xfer(mk(1'b1, 3'd2, 16'h0008), 14, 0, -1, rd, sn, ba);
        exp_err++; exp_addr = 3'd2;
        n_checks++; if (wr_cnt !== exp_wr) begin n_errs++; $display("FAIL abort_no_write: got %0d want %0d", wr_cnt, exp_wr); end
        n_checks++; if (err_cnt !== exp_err) begin n_errs++; $display("FAIL abort_err: got %0d want %0d", err_cnt, exp_err); end
        n_checks++; if (err_long !== 0) begin n_errs++; $display("FAIL abort_err_width: got %0d long pulses want 0", err_long); end
        n_checks++; if (cfg_address !== exp_addr) begin n_errs++; $display("FAIL abort_addr_kept: got %0d want %0d", cfg_address, exp_addr); end
        do_read(3'd2, rd);
        n_checks++; if (rd !== exp_mem[2]) begin n_errs++; $display("FAIL abort_readback: got %h want %h", rd, exp_mem[2]); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd; logic [22:0] sn; logic ba;
        xfer(mk(1'b1, 3'd5, 16'h9089), NB, 0, 10, rd, sn, ba);
        exp_addr = 3'd0; exp_din = 16'h0;
        n_checks++; if (sn !== 23'h0) begin n_errs++; $display("FAIL rstmid_outputs: got %h want 0", sn); end
        n_checks++; if (ba !== 1'b0) begin n_errs++; $display("FAIL rstmid_ignored_busy: got %b want 0", ba); end
        n_checks++; if (wr_cnt !== exp_wr) begin n_errs++; $display("FAIL rstmid_no_write: got %0d want %0d", wr_cnt, exp_wr); end
        n_checks++; if (err_cnt !== exp_err) begin n_errs++; $display("FAIL rstmid_err: got %0d want %0d", err_cnt, exp_err); end
        n_checks++; if (cfg_data_in !== exp_din) begin n_errs++; $display("FAIL rstmid_din: got %h want %h", cfg_data_in, exp_din); end
        do_read(3'd5, rd);
        exp_addr = 3'd5;
        n_checks++; if (rd !== exp_mem[5]) begin n_errs++; $display("FAIL rstmid_readback: got %h want %h", rd, exp_mem[5]); end
    endtask

    task automatic test_extra_sclk;
        logic [15:0] rd;
        do_write(3'd0, 16'h5555, 4);
        exp_wr++; exp_mem[0] = 16'h5555; exp_addr = 3'd0; exp_din = 16'h5555;
        n_checks++; if (wr_cnt !== exp_wr) begin n_errs++; $display("FAIL extra_single_write: got %0d want %0d", wr_cnt, exp_wr); end
        n_checks++; if (wr_data !== 16'h5555) begin n_errs++; $display("FAIL extra_data: got %h want 5555", wr_data); end
        n_checks++; if (err_cnt !== exp_err) begin n_errs++; $display("FAIL extra_err: got %0d want %0d", err_cnt, exp_err); end
        do_read(3'd0, rd);
        n_checks++; if (rd !== exp_mem[0]) begin n_errs++; $display("FAIL extra_readback: got %h want %h", rd, exp_mem[0]); end
    endtask

    task automatic test_random;
        logic [15:0] rd, d; logic [2:0] a; logic [22:0] sn; logic ba;
        int op, cut;
        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 2);
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            if (op == 0) begin
                do_write(a, d, 0);
                exp_wr++; exp_mem[a] = d; exp_addr = a; exp_din = d;
            end else if (op == 1) begin
                do_read(a, rd);
                exp_addr = a;
                n_checks++; if (rd !== exp_mem[a]) begin n_errs++; $display("FAIL rand_read it=%0d a=%0d: got %h want %h", it, a, rd, exp_mem[a]); end
            end else begin
                cut = $urandom_range(0, NB - 1);
                xfer(mk(1'($urandom), a, d), cut, 0, -1, rd, sn, ba);
                exp_err++;
                if (cut >= 4) exp_addr = a;
            end
            n_checks++; if (wr_cnt !== exp_wr) begin n_errs++; $display("FAIL rand_wr_count it=%0d: got %0d want %0d", it, wr_cnt, exp_wr); end
            n_checks++; if (err_cnt !== exp_err) begin n_errs++; $display("FAIL rand_err_count it=%0d: got %0d want %0d", it, err_cnt, exp_err); end
            n_checks++; if (cfg_address !== exp_addr) begin n_errs++; $display("FAIL rand_addr it=%0d: got %0d want %0d", it, cfg_address, exp_addr); end
            n_checks++; if (cfg_data_in !== exp_din) begin n_errs++; $display("FAIL rand_din it=%0d: got %h want %h", it, cfg_data_in, exp_din); end
            n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL rand_busy it=%0d: got %b want 0", it, busy); end
        end
        n_checks++; if (wr_long !== 0) begin n_errs++; $display("FAIL write_width: got %0d long pulses want 0", wr_long); end
        n_checks++; if (err_long !== 0) begin n_errs++; $display("FAIL err_width: got %0d long pulses want 0", err_long); end
    endtask

`ifdef CFG_PARITY_EN
    task automatic test_parity;
        logic [15:0] rd; logic [22:0] sn; logic ba;
        xfer(mk(1'b1, 3'd1, 16'h9988) ^ 21'h1, NB, 0, -1, rd, sn, ba);
        exp_err++; exp_addr = 3'd1;
        n_checks++; if (wr_cnt !== exp_wr) begin n_errs++; $display("FAIL parity_bad_no_write: got %0d want %0d", wr_cnt, exp_wr); end
        n_checks++; if (err_cnt !== exp_err) begin n_errs++; $display("FAIL parity_bad_err: got %0d want %0d", err_cnt, exp_err); end
        do_write(3'd1, 16'h9988, 0);
        exp_wr++; exp_mem[1] = 16'h9988; exp_din = 16'h9988;
        n_checks++; if (wr_cnt !== exp_wr) begin n_errs++; $display("FAIL parity_good_write: got %0d want %0d", wr_cnt, exp_wr); end
        n_checks++; if (wr_data !== 16'h9988) begin n_errs++; $display("FAIL parity_good_data: got %h want 9988", wr_data); end
        do_read(3'd1, rd);
        n_checks++; if (rd !== exp_mem[1]) begin n_errs++; $display("FAIL parity_readback: got %h want %h", rd, exp_mem[1]); end
        xfer(mk(1'b0, 3'd1, 16'h1234) ^ 21'h1, NB, 0, -1, rd, sn, ba);
        exp_err++;
        n_checks++; if (rd !== exp_mem[1]) begin n_errs++; $display("FAIL parity_bad_read_data: got %h want %h", rd, exp_mem[1]); end
        n_checks++; if (err_cnt !== exp_err) begin n_errs++; $display("FAIL parity_bad_read_err: got %0d want %0d", err_cnt, exp_err); end
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) exp_mem[i] = def_val(i);
        test_reset;
        test_read_defaults;
        test_write_read;
        test_abort;
        test_reset_mid;
        test_extra_sclk;
`ifdef CFG_PARITY_EN
        test_parity;
`endif
        test_random;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/config_ser_bridge.md
Name: config_ser_bridge

Overview:
- Serial-to-parallel command front end that sits directly upstream of config_reg and owns its write/address/data_in inputs.
- Accepts SPI-style frames (mode 0, MSB first) on cs_n/sclk/mosi and oversamples them in the clk domain.
- Turns each write frame into one config_reg write pulse.
- Serves each read frame by presenting the address to config_reg, capturing data_out and shifting it back on miso.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on cs_n/sclk/mosi (legal values 2..4).
- RD_LAT, 1, clk cycles from cfg_address valid to cfg_data_out valid (legal values 1..3).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- cs_n  input  1  serial chip select, active low, asynchronous to clk.
- sclk  input  1  serial clock, asynchronous to clk; frequency <= clk/8.
- mosi  input  1  serial data in.
- miso  output  1  serial data out.
- cfg_write  output  1  write strobe to config_reg.
- cfg_address  output  3  register index to config_reg (0 = adc0_reg .. 7 = digital_config).
- cfg_data_in  output  16  write data to config_reg.
- cfg_data_out  input  16  read data from config_reg.
- busy  output  1  high while a frame is in progress.
- frame_err  output  1  1-cycle pulse when a frame is aborted or rejected.

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; miso=0; cfg_write=0; cfg_address=0; cfg_data_in=0; busy=0; frame_err=0; shift/bit counters=0; synchronizer flops=idle values (cs_n=1, sclk=0).
- Input conditioning: cs_n, sclk and mosi each pass through SYNC_STAGES flops. Edge detection uses the synchronized sclk. mosi is sampled on the synchronized sclk rise; miso is updated on the synchronized sclk fall.
- Frame format, 20 bits: bit19 = RW (1 = write); bits18:16 = address; bits15:0 = data (write) or don't-care (read).
- State IDLE -> HDR on synchronized cs_n falling edge; busy=1; bit counter cleared.
- HDR: shifts 4 bits. On the 4th sclk rise, cfg_address <= header address.
  - RW=0 -> RD_WAIT.
  - RW=1 -> DATA.
- RD_WAIT: waits exactly RD_LAT clk cycles, then loads cfg_data_out into the tx shift register -> DATA.
  - miso presents tx bit15 on the next sclk fall; each later fall shifts the next bit out, MSB first.
- DATA: shifts 16 bits.
  - Write frame: on the 16th rise -> COMMIT.
  - Read frame: stays in DATA until cs_n rises, then -> IDLE. miso returns to 0 one clk after cs_n rises.
- COMMIT, single cycle: cfg_data_in <= assembled data; cfg_write=1 for exactly 1 clk -> DONE.
  - cfg_address and cfg_data_in hold until the next frame's header completes.
- DONE: ignores further sclk edges; cs_n rise -> IDLE, busy=0.
- Abort: cs_n rises in HDR, RD_WAIT or DATA before the bit count is complete:
  - no cfg_write;
  - frame_err pulses 1 cycle;
  - -> IDLE;
  - already-latched cfg_address is kept.
- Extra sclk edges beyond bit 20 are ignored; no second write.
- cfg_write is never asserted outside COMMIT. At most one write per cs_n assertion.
- Reset mid-frame: the frame is discarded and no write is issued. After reset release, a frame in progress (cs_n already low) is ignored until cs_n goes high and then low again.
- Read data reflects config_reg contents at RD_WAIT expiry. A write to the same address in an earlier frame is visible in the read.

Optional Feature:
- Macro: CFG_PARITY_EN.
- Defined:
  - Frame is 21 bits; bit0 = even parity over bits20:1.
  - COMMIT happens only after the 21st rise and only if parity is correct.
  - Bad parity: no cfg_write; frame_err pulses; -> DONE.
  - Read frames: the parity bit is checked too. On failure, frame_err pulses and the miso data already sent is unaffected.
- Not defined: 20-bit frame, no parity logic; frame_err only flags aborts.

Test Plan:
- After reset, read frame addr 0 -> miso returns 0xFFFF. Read addr 4 -> 0xABCD. Read addr 7 -> 0x0001.
- Write frame addr 7, data 0xAA77 -> exactly one cfg_write pulse with cfg_address=7 and cfg_data_in=0xAA77. Then read addr 7 -> 0xAA77.
- Write addr 2 data 0x0008, then cs_n raised after 10 data bits -> no cfg_write; frame_err 1-cycle pulse. Read addr 2 -> 0x0000.
- reset=0 asserted during the DATA phase of a write to addr 5 data 0x9089 -> no write; all outputs at reset values. Next full read of addr 5 -> 0x0000.
- Write addr 0 data 0x5555 followed by 4 extra sclk pulses before cs_n rises -> single cfg_write. Read addr 0 -> 0x5555.
- With CFG_PARITY_EN: write addr 1 data 0x9988 with wrong parity -> no cfg_write; frame_err pulse. The same frame with correct parity -> write committed. Read addr 1 -> 0x9988.
